en_to_level: RTL

Converts single-cycle enable strobes (`set_en`, `clr_en`) back into a clean registered level with enforced minimum high and low widths. It is the transmit-side complement of the edge-to-enable detector: a downstream synchronizer and edge detector sees every commanded transition as one well-separated edge. It sits in the control path wherever FSM strobes must drive an external or cross-domain level such as a request line, LED, or GPIO.

---
 rtl/en_to_level.sv | 117 +++++++++++
 1 files changed

// File: rtl/en_to_level.sv
// Turns set/clr enable strobes into a registered level with minimum high/low widths.
// Optional `EN_TO_LEVEL_PEND_EN` adds a one-deep deferred-request register; otherwise late requests are dropped.
module en_to_level #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter bit INIT     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic       clr_en,
  output logic       out,
  output logic       busy,
  output logic       pend,
  output logic       drop,
  output logic [1:0] dbg_state
);

  localparam int MAX_MIN = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
  localparam int CW      = $clog2(MAX_MIN + 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(MIN_HIGH - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(MIN_LOW - 1);

`ifdef EN_TO_LEVEL_PEND_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  // Bit 1 of the encoding is the output level, so the current level is state[1].
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    LOW_HOLD  = 2'd1,
    HIGH_HOLD = 2'd2,
    HIGH      = 2'd3
  } state_t;

  localparam state_t RESET_STATE = INIT ? HIGH : LOW;

  state_t        state;
  logic [CW-1:0] cnt;

  logic   cur_level;
  logic   bounce;
  logic   req_opp;
  logic   req_cur;
  logic   pend_eff;
  state_t flip_state;
  state_t stable_state;
  logic [CW-1:0] flip_load;

  always_comb begin
    cur_level    = state[1];
    bounce       = set_en & clr_en;
    req_opp      = bounce | (cur_level ? (clr_en & ~set_en) : (set_en & ~clr_en));
    req_cur      = cur_level ? (set_en & ~clr_en) : (clr_en & ~set_en);
    // Latest request in this cycle overrides whatever was stored.
    pend_eff     = PEND_EN & (req_opp | (pend & ~req_cur));
    flip_state   = cur_level ? LOW_HOLD : HIGH_HOLD;
    flip_load    = cur_level ? LOW_LOAD : HIGH_LOAD;
    stable_state = cur_level ? HIGH : LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
      out   <= INIT;
      busy  <= 1'b0;
      pend  <= 1'b0;
      drop  <= 1'b0;
      cnt   <= '0;
    end else begin
      drop <= 1'b0;
      case (state)
        LOW, HIGH: begin
          if (req_opp) begin
            state <= flip_state;
            out   <= ~cur_level;
            busy  <= 1'b1;
            cnt   <= flip_load;
            pend  <= PEND_EN & bounce;
            drop  <= ~PEND_EN & bounce;
          end
        end
        LOW_HOLD, HIGH_HOLD: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            pend <= pend_eff;
            drop <= ~PEND_EN & req_opp;
          end else if (pend_eff) begin
            // Expiry with a deferred flip: straight into the opposite hold, no idle gap.
            state <= flip_state;
            out   <= ~cur_level;
            busy  <= 1'b1;
            cnt   <= flip_load;
            pend  <= 1'b0;
          end else begin
            state <= stable_state;
            busy  <= 1'b0;
            pend  <= 1'b0;
            drop  <= ~PEND_EN & req_opp;
          end
        end
        default: begin
          state <= RESET_STATE;
          out   <= INIT;
          busy  <= 1'b0;
          pend  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
